led_pattern_engine: RTL and testbench

LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

---
 rtl/led_pat_pkg.sv | 31 +++
 rtl/led_step_timer.sv | 43 ++++
 rtl/led_pattern_engine.sv | 146 ++++++++++++++
 tb/tb_led_pattern_engine.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/led_pat_pkg.sv
// Shared constants for the LED pattern engine: pattern codes, sparkle LFSR
// parameters and the per-pattern state record.
package led_pat_pkg;

  localparam logic [2:0] PAT_SCAN    = 3'd0;
  localparam logic [2:0] PAT_PAIR    = 3'd1;
  localparam logic [2:0] PAT_EXPAND  = 3'd2;
  localparam logic [2:0] PAT_BLINK   = 3'd3;
  localparam logic [2:0] PAT_ALT     = 3'd4;
  localparam logic [2:0] PAT_MARQUEE = 3'd5;
  localparam logic [2:0] PAT_SPARKLE = 3'd6;
  localparam logic [2:0] PAT_OFF     = 3'd7;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Position/direction are shared by scanner and walking pair; idx drives
  // expand/contract. Widths cover the largest supported strip (16 LEDs).
  typedef struct packed {
    logic [3:0]  pos;
    logic        dir;   // 0 = moving up, 1 = moving down
    logic [3:0]  idx;
    logic [15:0] lfsr;
  } pat_state_t;

  // One Galois LFSR step: shift right, fold taps in when a 1 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step-period counter plus single-step edge detector. Emits a one-cycle
// advance strobe (combinational from registered state and inputs).
module led_step_timer
  import led_pat_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             pause,
  input  logic             step_req,
  input  logic [DIV_W-1:0] period,
  output logic             adv
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] term;
  logic             sreq_q;
  logic             run;
  logic             wrap;

  // Period 0 behaves as 1; ">=" lets a shrunk period wrap immediately.
  assign term = (period == '0) ? '0 : period - ONE;
  assign run  = ena && !pause;
  assign wrap = (cnt >= term);
  assign adv  = (run && wrap) || (ena && pause && step_req && !sreq_q);

  // Free-running step counter, held while disabled or paused.
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (run) cnt <= wrap ? '0 : cnt + ONE;
  end

  // Previous step_req level so a held request fires only once.
  always_ff @(posedge clk) begin
    if (rst) sreq_q <= 1'b0;
    else     sreq_q <= step_req;
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: step timer drives frame advances; each advance either
// (re)loads the selected pattern or moves the running one forward a frame.
module led_pattern_engine
  import led_pat_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int DIV_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [2:0]        pat_sel,
  input  logic [DIV_W-1:0]  period,
  input  logic              pause,
  input  logic              step_req,
  output logic [N_LEDS-1:0] led_out,
  output logic              step_tick,
  output logic [2:0]        pat_cur
);

  localparam logic [3:0] SCAN_TOP = 4'(N_LEDS - 1);
  localparam logic [3:0] PAIR_TOP = 4'(N_LEDS - 2);
  localparam logic [3:0] IDX_TOP  = 4'(N_LEDS - 1);

  logic              adv;
  logic              loaded;
  pat_state_t        st, st_n;
  logic [N_LEDS-1:0] led_n;
  logic [2:0]        pat_n;
  logic [4:0]        bnc;

  led_step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .pause    (pause),
    .step_req (step_req),
    .period   (period),
    .adv      (adv)
  );

  // Bounce one step between 0 and top; endpoints are shown only once.
  function automatic logic [4:0] bounce(input logic [3:0] p, input logic d,
                                        input logic [3:0] top);
    if (!d) return (p >= top)   ? {1'b1, p - 4'd1} : {1'b0, p + 4'd1};
    else    return (p == 4'd0)  ? {1'b0, 4'd1}     : {1'b1, p - 4'd1};
  endfunction

  function automatic logic [N_LEDS-1:0] dot(input logic [3:0] p, input logic two);
    logic [N_LEDS-1:0] f;
    for (int b = 0; b < N_LEDS; b++)
      f[b] = (b == int'(p)) || (two && (b == int'(p) + 1));
    return f;
  endfunction

  // Centred bar of half-width k; k rises to N/2 then falls back to 0.
  function automatic logic [N_LEDS-1:0] bar(input logic [3:0] i);
    logic [N_LEDS-1:0] f;
    int k;
    k = (int'(i) < N_LEDS/2) ? int'(i) + 1 : N_LEDS - 1 - int'(i);
    for (int b = 0; b < N_LEDS; b++)
      f[b] = (b >= N_LEDS/2 - k) && (b < N_LEDS/2 + k);
    return f;
  endfunction

  function automatic logic [N_LEDS-1:0] odd_bits();
    logic [N_LEDS-1:0] f;
    for (int b = 0; b < N_LEDS; b++) f[b] = ((b % 2) == 1);
    return f;
  endfunction

  function automatic logic [N_LEDS-1:0] low3();
    logic [N_LEDS-1:0] f;
    for (int b = 0; b < N_LEDS; b++) f[b] = (b < 3);
    return f;
  endfunction

  // Next frame/state for the coming advance: reload or step the pattern.
  always_comb begin
    st_n  = st;
    led_n = led_out;
    pat_n = pat_cur;
    bnc   = '0;
    if (!loaded || (pat_sel != pat_cur)) begin
      pat_n = pat_sel;
      st_n  = '{pos: 4'd0, dir: 1'b0, idx: 4'd0, lfsr: LFSR_SEED};
      case (pat_sel)
        PAT_SCAN:    led_n = dot(4'd0, 1'b0);
        PAT_PAIR:    led_n = dot(4'd0, 1'b1);
        PAT_EXPAND:  led_n = bar(4'd0);
        PAT_BLINK:   led_n = '1;
        PAT_ALT:     led_n = odd_bits();
        PAT_MARQUEE: led_n = low3();
        PAT_SPARKLE: led_n = LFSR_SEED[N_LEDS-1:0];
        default:     led_n = '0;
      endcase
    end else begin
      case (pat_cur)
        PAT_SCAN: begin
          bnc      = bounce(st.pos, st.dir, SCAN_TOP);
          st_n.dir = bnc[4];
          st_n.pos = bnc[3:0];
          led_n    = dot(bnc[3:0], 1'b0);
        end
        PAT_PAIR: begin
          bnc      = bounce(st.pos, st.dir, PAIR_TOP);
          st_n.dir = bnc[4];
          st_n.pos = bnc[3:0];
          led_n    = dot(bnc[3:0], 1'b1);
        end
        PAT_EXPAND: begin
          st_n.idx = (st.idx >= IDX_TOP) ? 4'd0 : st.idx + 4'd1;
          led_n    = bar(st_n.idx);
        end
        PAT_BLINK:   led_n = ~led_out;
        PAT_ALT:     led_n = ~led_out;
        PAT_MARQUEE: led_n = {led_out[N_LEDS-2:0], led_out[N_LEDS-1]};
        PAT_SPARKLE: begin
          st_n.lfsr = lfsr_step(st.lfsr);
          led_n     = st_n.lfsr[N_LEDS-1:0];
        end
        default:     led_n = '0;
      endcase
    end
  end

  // Outputs and pattern state move only on an advance; ena=0 freezes all.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_out   <= '0;
      step_tick <= 1'b0;
      pat_cur   <= PAT_SCAN;
      loaded    <= 1'b0;
      st        <= '{pos: 4'd0, dir: 1'b0, idx: 4'd0, lfsr: LFSR_SEED};
    end else if (ena) begin
      step_tick <= adv;
      if (adv) begin
        led_out <= led_n;
        pat_cur <= pat_n;
        st      <= st_n;
        loaded  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench: stimulus queues hand-computed frames, a negedge monitor
// pops one per fresh step_tick and checks frame, pattern and tick spacing.
module tb_led_pattern_engine;

  localparam int N = 8;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst, ena, pause, step_req;
  logic [2:0]    pat_sel;
  logic [DW-1:0] period;
  logic [N-1:0]  led_out;
  logic          step_tick;
  logic [2:0]    pat_cur;

  typedef struct {
    logic [N-1:0] led;
    logic [2:0]   pat;
    int           gap;   // expected cycles since previous tick, 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_tick = 0;
  logic ena_q = 1'b0;

  led_pattern_engine #(.N_LEDS(N), .DIV_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .pat_sel   (pat_sel),
    .period    (period),
    .pause     (pause),
    .step_req  (step_req),
    .led_out   (led_out),
    .step_tick (step_tick),
    .pat_cur   (pat_cur)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ena_q <= ena;
  end

  // A tick is fresh only if the edge that produced it had ena high.
  always @(negedge clk) begin
    if (step_tick && ena_q) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick cyc=%0d led_out=%h pat_cur=%0d", cyc, led_out, pat_cur);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (led_out !== e.led || pat_cur !== e.pat) begin
          errors++;
          $display("FAIL frame cyc=%0d got led=%h pat=%0d want led=%h pat=%0d",
                   cyc, led_out, pat_cur, e.led, e.pat);
        end
        if (e.gap != 0) begin
          checks++;
          if (cyc - last_tick != e.gap) begin
            errors++;
            $display("FAIL tick_gap cyc=%0d got %0d want %0d", cyc, cyc - last_tick, e.gap);
          end
        end
      end
      last_tick = cyc;
    end
  end

  task automatic push(input logic [N-1:0] led, input logic [2:0] pat, input int gap);
    exp_t e;
    e.led = led; e.pat = pat; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [N-1:0] scan_tbl [15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [N-1:0] exp_tbl  [9]  = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00, 8'h18};
  logic [N-1:0] lfsr_tbl [5]  = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'h4E};

  initial begin
    rst = 1'b1; ena = 1'b1; pause = 1'b0; step_req = 1'b0;
    pat_sel = 3'd0; period = 24'd4;
    cycles(3);
    check("reset_led", 32'(led_out), 32'h0);
    check("reset_tick", 32'(step_tick), 32'h0);
    check("reset_pat", 32'(pat_cur), 32'h0);

    // Scanner at period 4: full bounce, first frame 4 cycles after release.
    for (int i = 0; i < 15; i++) push(scan_tbl[i], 3'd0, (i == 0) ? 0 : 4);
    rst = 1'b0;
    cycles(3);
    check("pre_first_adv_led", 32'(led_out), 32'h0);
    cycles(1);
    check("first_adv_led", 32'(led_out), 32'h01);
    check("first_adv_tick", 32'(step_tick), 32'h1);
    cycles(56);

    // Expand/contract, one frame per cycle.
    pat_sel = 3'd2; period = 24'd1;
    for (int i = 0; i < 9; i++) push(exp_tbl[i], 3'd2, 1);
    cycles(9);

    // Marquee to 0x1C, then switch to blink mid-period.
    pat_sel = 3'd5; period = 24'd4;
    push(8'h07, 3'd5, 4); push(8'h0E, 3'd5, 4); push(8'h1C, 3'd5, 4);
    push(8'hFF, 3'd3, 4); push(8'h00, 3'd3, 4);
    cycles(13);
    check("marquee_mid", 32'(led_out), 32'h1C);
    pat_sel = 3'd3;
    cycles(7);

    // Pause: silence, then single steps from held requests.
    pause = 1'b1;
    cycles(20);
    check("pause_led_held", 32'(led_out), 32'h00);
    check("pause_no_tick", 32'(step_tick), 32'h0);
    push(8'hFF, 3'd3, 0);
    step_req = 1'b1; cycles(3);
    step_req = 1'b0; cycles(3);
    push(8'h00, 3'd3, 0);
    step_req = 1'b1; cycles(1);
    step_req = 1'b0; cycles(2);

    // Period 0 means every cycle; ena low freezes everything.
    pause = 1'b0; period = 24'd0; pat_sel = 3'd4;
    push(8'hAA, 3'd4, 0); push(8'h55, 3'd4, 1); push(8'hAA, 3'd4, 1); push(8'h55, 3'd4, 1);
    cycles(4);
    ena = 1'b0;
    cycles(10);
    check("freeze_led", 32'(led_out), 32'h55);
    check("freeze_tick", 32'(step_tick), 32'h1);
    push(8'hAA, 3'd4, 0); push(8'h55, 3'd4, 1);
    ena = 1'b1;
    cycles(2);

    // Shrinking period below the running count wraps at once.
    period = 24'd8; pat_sel = 3'd7;
    push(8'h00, 3'd7, 6); push(8'h00, 3'd7, 3);
    cycles(5);
    period = 24'd3;
    cycles(4);

    // Reset mid-stream, then sparkle from a clean start.
    rst = 1'b1; pat_sel = 3'd6; period = 24'd1; pause = 1'b1; step_req = 1'b1;
    cycles(2);
    check("rst2_led", 32'(led_out), 32'h0);
    check("rst2_pat", 32'(pat_cur), 32'h0);
    check("rst2_tick", 32'(step_tick), 32'h0);
    pause = 1'b0; step_req = 1'b0;
    for (int i = 0; i < 5; i++) push(lfsr_tbl[i], 3'd6, (i == 0) ? 0 : 1);
    rst = 1'b0;
    cycles(5);
    ena = 1'b0;
    cycles(3);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
